// File: rtl/cache_set_assoc.sv
// cache_set_assoc: N-way set-associative write-back cache with per-set true-LRU, dirty-line eviction port and a flush walk
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_op/req_addr/req_data request handshake
//        (op 00 FLUSH, 01 READ, 10 WRITE, 11 INVALIDATE; addr = {tag, index});
//        resp_valid/resp_hit/resp_data one-cycle response; evict_valid/evict_addr/evict_data dirty victim write-back.
module cache_set_assoc #(
    parameter int TAG_WIDTH   = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int WAYS        = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [1:0]                       req_op,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]            req_data,
    output logic                             resp_valid,
    output logic                             resp_hit,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             evict_valid,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] evict_addr,
    output logic [DATA_WIDTH-1:0]            evict_data
);
    localparam int SETS  = 2 ** INDEX_WIDTH;
    localparam int AGE_W = $clog2(WAYS);
    localparam int EW    = INDEX_WIDTH + AGE_W;
    localparam logic [1:0] OP_FLUSH = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10, OP_INV = 2'b11;

    typedef enum logic {IDLE, FLUSH} state_t;
    state_t state, state_next;

    logic                  valid    [SETS][WAYS];
    logic                  dirty    [SETS][WAYS];
    logic [TAG_WIDTH-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_mem [SETS][WAYS];
    logic [AGE_W-1:0]      age      [SETS][WAYS];

    // Flush walk pointer {set, way}; it wraps back to 0 after the last entry.
    logic [EW-1:0]          ptr;
    logic [INDEX_WIDTH-1:0] idx, fset;
    logic [TAG_WIDTH-1:0]   rtag;
    logic [WAYS-1:0]        hit_vec;
    logic                   hit, has_inv, accept, do_lru;
    logic [AGE_W-1:0]       hit_way, inv_way, lru_way, vict, tw, tw_age, fway;

    assign req_ready = !reset && state == IDLE;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[INDEX_WIDTH-1:0];
    assign rtag      = req_addr[TAG_WIDTH+INDEX_WIDTH-1:INDEX_WIDTH];
    assign fset      = ptr[EW-1:AGE_W];
    assign fway      = ptr[AGE_W-1:0];

    // Descending scan so the lowest-numbered matching/invalid way wins.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        lru_way = '0;
        has_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid[idx][w] && tag_mem[idx][w] == rtag;
            if (hit_vec[w]) hit_way = AGE_W'(w);
            if (!valid[idx][w]) begin
                inv_way = AGE_W'(w);
                has_inv = 1'b1;
            end
            if (age[idx][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
        end
    end

    assign hit    = |hit_vec;
    assign vict   = has_inv ? inv_way : lru_way;
    assign tw     = hit ? hit_way : vict;
    assign tw_age = age[idx][tw];
    assign do_lru = accept && ((req_op == OP_READ && hit) || req_op == OP_WRITE);

    always_comb begin
        state_next = (accept && req_op == OP_FLUSH) ? FLUSH : (state == FLUSH && &ptr) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_data   <= '0;
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_data  <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= AGE_W'(w);
                end
        end else begin
            state       <= state_next;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_data   <= '0;
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_data  <= '0;
            if (state == FLUSH) begin
                ptr <= ptr + EW'(1);
                if (valid[fset][fway] && dirty[fset][fway]) begin
                    evict_valid <= 1'b1;
                    evict_addr  <= {tag_mem[fset][fway], fset};
                    evict_data  <= data_mem[fset][fway];
                end
                valid[fset][fway] <= 1'b0;
                dirty[fset][fway] <= 1'b0;
                age[fset][fway]   <= fway;
                resp_valid        <= &ptr;
            end else if (accept && req_op != OP_FLUSH) begin
                resp_valid <= 1'b1;
                resp_hit   <= hit;
                if (req_op == OP_READ && hit) resp_data <= data_mem[idx][hit_way];
                if (req_op == OP_WRITE) begin
                    if (!hit && valid[idx][vict] && dirty[idx][vict]) begin
                        evict_valid <= 1'b1;
                        evict_addr  <= {tag_mem[idx][vict], idx};
                        evict_data  <= data_mem[idx][vict];
                    end
                    valid[idx][tw] <= 1'b1;
                    dirty[idx][tw] <= 1'b1;
                end
                if (req_op == OP_INV && hit) begin
                    valid[idx][hit_way] <= 1'b0;
                    dirty[idx][hit_way] <= 1'b0;
                end
                // Ways younger than the touched way age by one; the touched way becomes MRU.
                if (do_lru)
                    for (int w = 0; w < WAYS; w++)
                        if (AGE_W'(w) == tw) age[idx][w] <= '0;
                        else if (age[idx][w] < tw_age) age[idx][w] <= age[idx][w] + AGE_W'(1);
            end
        end
    end

    // Tag and data arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (accept && req_op == OP_WRITE) begin
            tag_mem[idx][tw]  <= rtag;
            data_mem[idx][tw] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_op != OP_FLUSH) assert ($onehot0(hit_vec)) else $error("multiple ways matched tag");
    end
endmodule

// File: tb/tb_cache_set_assoc.sv
// tb_cache_set_assoc: table vectors, flush corner sequences and random traffic against a recency-list cache model
module tb_cache_set_assoc;
    localparam int SETS = 4, WAYS = 4, ENT = 16;
    localparam logic [1:0] OP_F = 2'b00, OP_R = 2'b01, OP_W = 2'b10, OP_I = 2'b11;

    logic       clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [5:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, resp_valid, resp_hit, evict_valid;
    logic [7:0] resp_data, evict_data;
    logic [5:0] evict_addr;

    always #5 clk = ~clk;

    cache_set_assoc dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_data(resp_data), .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data)
    );

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: ord[s][p] is the way whose recency rank is p (0 = most recent).
    logic       mv [SETS][WAYS], md [SETS][WAYS];
    logic [3:0] mt [SETS][WAYS];
    logic [7:0] mdat [SETS][WAYS];
    int         ord [SETS][WAYS];
    logic       e_hit, e_ev;
    logic [7:0] e_rd, e_ed;
    logic [5:0] e_ea;

    task automatic m_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                ord[s][w] = w;
            end
    endtask

    task automatic touch(input int s, input int w);
        int p = 0;
        for (int q = 0; q < WAYS; q++) if (ord[s][q] == w) p = q;
        for (int q = p; q > 0; q--) ord[s][q] = ord[s][q-1];
        ord[s][0] = w;
    endtask

    task automatic m_op(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d);
        int s = int'(a[1:0]);
        int h = -1;
        int v = -1;
        for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == a[5:2]) h = w;
        e_hit = h >= 0;
        e_rd = '0; e_ev = 1'b0; e_ea = '0; e_ed = '0;
        if (op == OP_R && h >= 0) begin
            e_rd = mdat[s][h];
            touch(s, h);
        end else if (op == OP_W && h >= 0) begin
            mdat[s][h] = d;
            md[s][h] = 1'b1;
            touch(s, h);
        end else if (op == OP_W) begin
            for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
            if (v < 0) v = ord[s][WAYS-1];
            if (mv[s][v] && md[s][v]) begin
                e_ev = 1'b1;
                e_ea = {mt[s][v], a[1:0]};
                e_ed = mdat[s][v];
            end
            mv[s][v] = 1'b1; md[s][v] = 1'b1; mt[s][v] = a[5:2]; mdat[s][v] = d;
            touch(s, v);
        end else if (op == OP_I && h >= 0) begin
            mv[s][h] = 1'b0;
            md[s][h] = 1'b0;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d);
        chk("ready_before_req", req_ready, 1);
        m_op(op, a, d);
        req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", req_ready, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_evict_valid", evict_valid, 0);
        chk("rst_evict_addr", evict_addr, 0);
        chk("rst_evict_data", evict_data, 0);
        m_reset();
    endtask

    // Walk check: sampled once per cycle after the accept edge; abort_j >= 0 asserts reset after that sample.
    task automatic flush(input int abort_j, output int pulses, output int low);
        logic       ev [ENT];
        logic [5:0] ea [ENT];
        logic [7:0] ed [ENT];
        for (int e = 0; e < ENT; e++) begin
            ev[e] = mv[e / WAYS][e % WAYS] && md[e / WAYS][e % WAYS];
            ea[e] = ev[e] ? {mt[e / WAYS][e % WAYS], 2'(e / WAYS)} : 6'h0;
            ed[e] = ev[e] ? mdat[e / WAYS][e % WAYS] : 8'h0;
        end
        pulses = 0;
        low = 0;
        chk("ready_before_flush", req_ready, 1);
        req_valid = 1'b1; req_op = OP_F; req_addr = 6'($urandom);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int j = 0; j <= ENT; j++) begin
            if (j == 0) chk("flush_ev_first", evict_valid, 0);
            else begin
                chk($sformatf("flush_ev_e%0d", j - 1), evict_valid, ev[j-1]);
                chk($sformatf("flush_eaddr_e%0d", j - 1), evict_addr, ea[j-1]);
                chk($sformatf("flush_edata_e%0d", j - 1), evict_data, ed[j-1]);
            end
            pulses += int'(evict_valid);
            low += int'(!req_ready);
            chk($sformatf("flush_ready_c%0d", j), req_ready, j == ENT);
            chk($sformatf("flush_resp_c%0d", j), resp_valid, j == ENT);
            if (j == ENT) chk("flush_resp_hit", resp_hit, 0);
            if (j == abort_j) begin
                do_reset();
                return;
            end
            if (j < ENT) @(negedge clk);
        end
        m_reset();
    endtask

    typedef struct packed {
        logic       rst;
        logic [1:0] op;
        logic [5:0] addr;
        logic [7:0] data;
        logic       hit;
        logic [7:0] rdata;
        logic       ev;
        logic [5:0] eaddr;
        logic [7:0] edata;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 400000", $time);
        $fatal(1);
    end

    initial begin
        int p, l;
        tbl.push_back('{1'b1, OP_R, 6'h00, 8'h00, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_R, 6'h25, 8'h00, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_W, 6'h25, 8'hA5, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_R, 6'h25, 8'h00, 1'b1, 8'hA5, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b1, OP_R, 6'h00, 8'h00, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_W, 6'h01, 8'h10, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_W, 6'h05, 8'h11, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_W, 6'h09, 8'h12, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_W, 6'h0D, 8'h13, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_R, 6'h01, 8'h00, 1'b1, 8'h10, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_W, 6'h11, 8'h44, 1'b0, 8'h00, 1'b1, 6'h05, 8'h11});
        tbl.push_back('{1'b0, OP_R, 6'h01, 8'h00, 1'b1, 8'h10, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_R, 6'h05, 8'h00, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_R, 6'h11, 8'h00, 1'b1, 8'h44, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b1, OP_R, 6'h00, 8'h00, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_W, 6'h3A, 8'h7E, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_I, 6'h3A, 8'h00, 1'b1, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_R, 6'h3A, 8'h00, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        tbl.push_back('{1'b0, OP_I, 6'h3A, 8'h00, 1'b0, 8'h00, 1'b0, 6'h00, 8'h00});
        m_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            else begin
                send(tbl[i].op, tbl[i].addr, tbl[i].data);
                chk($sformatf("tv%0d_valid", i), resp_valid, 1);
                chk($sformatf("tv%0d_hit", i), resp_hit, tbl[i].hit);
                chk($sformatf("tv%0d_data", i), resp_data, tbl[i].rdata);
                chk($sformatf("tv%0d_ev", i), evict_valid, tbl[i].ev);
                chk($sformatf("tv%0d_eaddr", i), evict_addr, tbl[i].eaddr);
                chk($sformatf("tv%0d_edata", i), evict_data, tbl[i].edata);
            end
        end

        do_reset();
        send(OP_W, 6'h00, 8'h11);
        send(OP_W, 6'h0F, 8'h22);
        flush(-1, p, l);
        chk("drain_pulses", p, 2);
        chk("drain_ready_low", l, 16);
        send(OP_R, 6'h00, 8'h00);
        chk("drain_rd00_hit", resp_hit, 0);
        send(OP_R, 6'h0F, 8'h00);
        chk("drain_rd0f_hit", resp_hit, 0);

        do_reset();
        send(OP_W, 6'h00, 8'hA0);
        send(OP_W, 6'h04, 8'hA1);
        send(OP_W, 6'h08, 8'hA2);
        send(OP_W, 6'h01, 8'hA3);
        flush(3, p, l);
        chk("abort_pulses", p, 3);
        @(negedge clk);
        chk("abort_no_resp", resp_valid, 0);
        chk("abort_no_evict", evict_valid, 0);
        send(OP_R, 6'h00, 8'h00);
        chk("abort_rd00_hit", resp_hit, 0);
        send(OP_R, 6'h01, 8'h00);
        chk("abort_rd01_hit", resp_hit, 0);
        send(OP_R, 6'h08, 8'h00);
        chk("abort_rd08_hit", resp_hit, 0);

        for (int i = 0; i < 600; i++) begin
            int r = int'($urandom_range(0, 49));
            logic [5:0] a = {4'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
            logic [7:0] d = 8'($urandom);
            if (r == 0) flush(-1, p, l);
            else begin
                send(r < 20 ? OP_R : r < 42 ? OP_W : OP_I, a, d);
                chk("rnd_valid", resp_valid, 1);
                chk("rnd_hit", resp_hit, e_hit);
                chk("rnd_data", resp_data, e_rd);
                chk("rnd_ev", evict_valid, e_ev);
                chk("rnd_eaddr", evict_addr, e_ea);
                chk("rnd_edata", evict_data, e_ed);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
